// File: rtl/vram_frame_capture.sv
// vram_frame_capture: snapshots a vector-RAM window on each GODVG rise
// and streams the bytes out on a valid/ready port tagged with the frame.
module vram_frame_capture #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 8,
  parameter int FRAME_W = 10,
  parameter int SKIP_W  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               godvg,
  input  logic [ADDR_W-1:0]  cfg_base,
  input  logic [ADDR_W-1:0]  cfg_len,
  input  logic [SKIP_W-1:0]  cfg_skip,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_first,
  output logic               out_last,
  output logic [FRAME_W-1:0] out_frame,
  output logic               busy,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [7:0]         drop_cnt
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state;
  logic              godvg_q;
  logic [SKIP_W-1:0] skip_ctr;
  logic [ADDR_W-1:0] rd_left;
  logic              rd_first;
  logic              rd_q;
  logic              rd_first_q;
  logic              rd_last_q;

  logic [DATA_W-1:0] buf_data [2];
  logic [1:0]        buf_first;
  logic [1:0]        buf_last;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  logic rise;
  logic pop;
  logic last_hs;
  logic open;
  logic start;
  logic skip;
  logic drop;
  logic rd_last;
  logic rd_done;

  assign rise      = godvg & ~godvg_q;
  assign out_valid = (count != 2'd0);
  assign out_data  = buf_data[rd_ptr];
  assign out_first = out_valid & buf_first[rd_ptr];
  assign out_last  = out_valid & buf_last[rd_ptr];
  assign busy      = (state != IDLE);

  assign pop     = out_valid & out_ready;
  assign last_hs = pop & out_last;
  // a rise that coincides with the final handshake starts the next frame
  assign open    = (state == IDLE) | last_hs;
  assign start   = rise & open & (skip_ctr == '0);
  assign skip    = rise & open & (skip_ctr != '0);
  assign drop    = rise & ~open;

  // read only when its data is sure to find a free slot next cycle
  assign mem_rd  = (state == READ) &
                   (({1'b0, count} + {2'b0, rd_q}) <
                    (3'd2 + {2'b0, pop}));
  assign rd_last = (rd_left == '0);
  assign rd_done = mem_rd & rd_last;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      godvg_q    <= 1'b0;
      skip_ctr   <= '0;
      rd_left    <= '0;
      rd_first   <= 1'b0;
      rd_q       <= 1'b0;
      rd_first_q <= 1'b0;
      rd_last_q  <= 1'b0;
      mem_addr   <= '0;
      out_frame  <= '0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      buf_first  <= '0;
      buf_last   <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= '0;
      for (int i = 0; i < 2; i++) buf_data[i] <= '0;
    end else begin
      godvg_q    <= godvg;
      rd_q       <= mem_rd;
      rd_first_q <= rd_first;
      rd_last_q  <= rd_last;
      if (rise) frame_cnt <= frame_cnt + 1'b1;
      if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 1'b1;
      if (skip) skip_ctr <= skip_ctr - 1'b1;
      if (mem_rd) begin
        mem_addr <= mem_addr + 1'b1;
        rd_left  <= rd_left - 1'b1;
        rd_first <= 1'b0;
      end
      unique case (1'b1)
        start: begin
          state     <= READ;
          skip_ctr  <= cfg_skip;
          mem_addr  <= cfg_base;
          rd_left   <= cfg_len;
          rd_first  <= 1'b1;
          out_frame <= frame_cnt;
        end
        rd_done:            state <= DRAIN;
        last_hs && !start:  state <= IDLE;
        default: ;
      endcase
      if (rd_q) begin
        buf_data[wr_ptr]  <= mem_data;
        buf_first[wr_ptr] <= rd_first_q;
        buf_last[wr_ptr]  <= rd_last_q;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, rd_q} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_vram_frame_capture.sv
// Directed bench for vram_frame_capture: table of capture windows plus
// hand sequences for decimation, drops, back-to-back and mid-stream reset.
`timescale 1ns/1ps
module tb_vram_frame_capture;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int FW = 10;
  localparam int SW = 4;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b0;
  logic          godvg    = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [AW-1:0] cfg_len  = '0;
  logic [SW-1:0] cfg_skip = '0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_first;
  logic          out_last;
  logic [FW-1:0] out_frame;
  logic          busy;
  logic [FW-1:0] frame_cnt;
  logic [7:0]    drop_cnt;

  vram_frame_capture dut (
    .clk(clk), .reset_n(reset_n), .godvg(godvg),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_skip(cfg_skip),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_first(out_first), .out_last(out_last),
    .out_frame(out_frame), .busy(busy),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ready_mode = 0;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    int            rmode;
    int            n;
    logic [DW-1:0] d_first;
    logic [DW-1:0] d_last;
  } vec_t;
  vec_t vt [5];

  logic [DW-1:0] bq_data [$];
  logic          bq_first [$];
  logic          bq_last [$];
  logic [FW-1:0] bq_frame [$];
  int            bq_cyc [$];
  logic [AW-1:0] aq [$];

  function automatic logic [DW-1:0] mval(input logic [AW-1:0] a);
    return a[7:0] ^ {3'b000, a[12:8]};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd) mem_data <= mval(mem_addr);

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom % 2);
  end

  logic          hold_p = 1'b0;
  logic [DW+1:0] hold_v = '0;

  initial forever begin
    @(negedge clk);
    if (hold_p)
      check("hold", 32'({out_valid, out_first, out_last, out_data}),
            32'({1'b1, hold_v}));
    hold_p = reset_n & out_valid & ~out_ready;
    hold_v = {out_first, out_last, out_data};
    if (mem_rd) aq.push_back(mem_addr);
    if (out_valid && out_ready) begin
      bq_data.push_back(out_data);
      bq_first.push_back(out_first);
      bq_last.push_back(out_last);
      bq_frame.push_back(out_frame);
      bq_cyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    bq_data.delete();
    bq_first.delete();
    bq_last.delete();
    bq_frame.delete();
    bq_cyc.delete();
    aq.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic wait_beats(input int n);
    for (int k = 0; k < 400 && bq_data.size() < n; k++) step(1);
  endtask

  int e;
  int c0;
  int errs;
  int frame_exp;
  int tq [$];
  int exp_tag [4];

  initial begin
    vt[0] = '{13'h0100, 13'd3,  0, 4,  8'h01, 8'h02};
    vt[1] = '{13'h1FFE, 13'd3,  0, 4,  8'hE1, 8'h01};
    vt[2] = '{13'h0040, 13'd0,  0, 1,  8'h40, 8'h40};
    vt[3] = '{13'h0A37, 13'd15, 1, 16, 8'h3D, 8'h4C};
    vt[4] = '{13'h1234, 13'd1,  0, 2,  8'h26, 8'h27};
    exp_tag = '{0, 3, 6, 9};

    @(posedge clk);
    #1;
    step(3);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd", 32'(mem_rd), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_cnts", 32'({frame_cnt, drop_cnt, out_frame}), 32'd0);
    check("rst_data", 32'({out_data, out_first, out_last}), 32'd0);
    reset_n = 1'b1;
    step(2);

    frame_exp = 0;
    for (int v = 0; v < 5; v++) begin
      cfg_base = vt[v].base;
      cfg_len = vt[v].len;
      ready_mode = vt[v].rmode;
      clear_logs();
      godvg = 1'b1;
      e = cyc + 1;
      step(1);
      check("start_busy", 32'(busy), 32'd1);
      check("start_rd", 32'({mem_rd, mem_addr}), 32'({1'b1, vt[v].base}));
      step(1);
      godvg = 1'b0;
      wait_beats(vt[v].n);
      step(4);
      ready_mode = 0;
      check("nbeats", 32'(bq_data.size()), 32'(vt[v].n));
      check("d_first", bq_data.size() > 0 ? 32'(bq_data[0]) : 32'hdead,
            32'(vt[v].d_first));
      check("d_last", bq_data.size() > 0 ? 32'(bq_data[$]) : 32'hdead,
            32'(vt[v].d_last));
      errs = 0;
      foreach (bq_data[i]) begin
        if (bq_data[i] !== mval(vt[v].base + AW'(i))) errs++;
        if (bq_first[i] !== (i == 0)) errs++;
        if (bq_last[i] !== (i == vt[v].n - 1)) errs++;
        if (bq_frame[i] !== FW'(frame_exp)) errs++;
      end
      check("beat_order", 32'(errs), 32'd0);
      errs = (aq.size() == vt[v].n) ? 0 : 1000;
      foreach (aq[i]) if (aq[i] !== vt[v].base + AW'(i)) errs++;
      check("addr_seq", 32'(errs), 32'd0);
      if (vt[v].rmode == 0 && bq_cyc.size() > 0) begin
        check("lat_first", 32'(bq_cyc[0]), 32'(e + 2));
        check("lat_last", 32'(bq_cyc[$]), 32'(e + 1 + vt[v].n));
      end
      check("end_busy", 32'(busy), 32'd0);
      check("end_fcnt", 32'(frame_cnt), 32'(frame_exp + 1));
      frame_exp++;
    end

    // decimation: capture every third frame
    do_reset();
    clear_logs();
    cfg_skip = 4'd2;
    cfg_base = 13'h0100;
    cfg_len = 13'd3;
    c0 = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      goto(c0 + 20 * i);
      godvg = 1'b1;
      step(2);
      godvg = 1'b0;
    end
    step(20);
    tq.delete();
    foreach (bq_first[i]) if (bq_first[i]) tq.push_back(int'(bq_frame[i]));
    check("skip_nfr", 32'(tq.size()), 32'd4);
    check("skip_nbeat", 32'(bq_data.size()), 32'd16);
    for (int i = 0; i < 4; i++)
      check("skip_tag", i < tq.size() ? 32'(tq[i]) : 32'hdead,
            32'(exp_tag[i]));
    check("skip_fcnt", 32'(frame_cnt), 32'd10);
    check("skip_drop", 32'(drop_cnt), 32'd0);
    cfg_skip = 4'd0;

    // drop mid-capture, then rise exactly on the last handshake
    do_reset();
    clear_logs();
    cfg_base = 13'h0200;
    cfg_len = 13'd15;
    godvg = 1'b1;
    e = cyc + 1;
    step(2);
    godvg = 1'b0;
    goto(e + 3);
    godvg = 1'b1;
    step(2);
    godvg = 1'b0;
    check("drop_cnt", 32'(drop_cnt), 32'd1);
    check("drop_fcnt", 32'(frame_cnt), 32'd2);
    check("drop_busy", 32'(busy), 32'd1);
    goto(e + 17);
    godvg = 1'b1;
    step(1);
    check("b2b_rd", 32'({busy, mem_rd, mem_addr}),
          32'({2'b11, 13'h0200}));
    check("b2b_cnts", 32'({frame_cnt, drop_cnt}), 32'({10'd3, 8'd1}));
    step(1);
    godvg = 1'b0;
    wait_beats(32);
    step(4);
    check("b2b_nbeat", 32'(bq_data.size()), 32'd32);
    check("b2b_lastcyc", bq_cyc.size() > 15 ? 32'(bq_cyc[15]) : 32'hdead,
          32'(e + 17));
    errs = 0;
    foreach (bq_data[i]) begin
      if (bq_data[i] !== mval(13'h0200 + AW'(i % 16))) errs++;
      if (bq_first[i] !== (i % 16 == 0)) errs++;
      if (bq_last[i] !== (i % 16 == 15)) errs++;
      if (bq_frame[i] !== ((i < 16) ? 10'd0 : 10'd2)) errs++;
    end
    check("b2b_order", 32'(errs), 32'd0);
    check("b2b_drop", 32'(drop_cnt), 32'd1);

    // reset in the middle of a stream
    do_reset();
    clear_logs();
    cfg_base = 13'h0300;
    godvg = 1'b1;
    e = cyc + 1;
    step(2);
    godvg = 1'b0;
    goto(e + 6);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    check("mr_valid", 32'({out_valid, busy, mem_rd}), 32'd0);
    check("mr_cnts", 32'({frame_cnt, drop_cnt, out_frame}), 32'd0);
    check("mr_out", 32'({mem_addr, out_data, out_first, out_last}), 32'd0);
    step(5);
    errs = 0;
    foreach (bq_last[i]) if (bq_last[i]) errs++;
    check("mr_nolast", 32'(errs), 32'd0);
    check("mr_quiet", 32'(out_valid), 32'd0);
    clear_logs();
    godvg = 1'b1;
    step(2);
    godvg = 1'b0;
    wait_beats(16);
    step(4);
    check("mr_nbeat", 32'(bq_data.size()), 32'd16);
    check("mr_tag", bq_frame.size() > 0 ? 32'(bq_frame[0]) : 32'hdead,
          32'd0);
    check("mr_fcnt", 32'(frame_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
